// File: rtl/svc_soc_run_monitor_pkg.sv
// rtl/svc_soc_run_monitor_pkg.sv - shared types for the SoC run-lifecycle monitor
package svc_soc_run_monitor_pkg;

    localparam int HALT_CODE_W = 32;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        END   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_PASS    = 3'd1,
        CAUSE_FAIL    = 3'd2,
        CAUSE_TIMEOUT = 3'd3,
        CAUSE_STALL   = 3'd4
    } cause_e;

endpackage

// File: rtl/svc_soc_run_monitor_hart.sv
// rtl/svc_soc_run_monitor_hart.sv - per-hart halt latch, exit-code register and retire gate
module svc_soc_run_monitor_hart
    import svc_soc_run_monitor_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   retire_i,
    input  logic                   halt_valid_i,
    input  logic [HALT_CODE_W-1:0] halt_code_i,
    output logic                   retire_o,
    output logic                   new_halt_o,
    output logic                   halted_o,
    output logic [HALT_CODE_W-1:0] code_o
);

    logic                   halted_q;
    logic                   halted_d;
    logic [HALT_CODE_W-1:0] code_q;
    logic [HALT_CODE_W-1:0] code_d;

    assign retire_o   = retire_i & ~halted_q;
    assign new_halt_o = halt_valid_i & ~halted_q;
    assign halted_o   = halted_q;
    // Effective exit code: the arriving one on the halting cycle, the latched one afterwards.
    assign code_o     = new_halt_o ? halt_code_i : code_q;

    always_comb begin
        halted_d = halted_q;
        code_d   = code_q;
        if (en_i && new_halt_o) begin
            halted_d = 1'b1;
            code_d   = halt_code_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halted_q <= 1'b0;
            code_q   <= '0;
        end else begin
            halted_q <= halted_d;
            code_q   <= code_d;
        end
    end

endmodule

// File: rtl/svc_soc_run_monitor.sv
// rtl/svc_soc_run_monitor.sv - multi-hart run controller: SoC reset sequencing, counters, end-of-run detection
module svc_soc_run_monitor
    import svc_soc_run_monitor_pkg::*;
#(
    parameter int NUM_HARTS       = 1,
    parameter int RESET_CYCLES    = 16,
    parameter int WATCHDOG_CYCLES = 500_000,
    parameter int STALL_CYCLES    = 10_000,
    parameter int CNT_W           = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_HARTS-1:0]               retire_i,
    input  logic [NUM_HARTS-1:0]               halt_valid_i,
    input  logic [NUM_HARTS*HALT_CODE_W-1:0]   halt_code_i,
    output logic                               soc_rst_o,
    output logic                               running_o,
    output logic                               done_o,
    output logic                               pass_o,
    output logic                               timeout_o,
    output logic                               stall_o,
    output logic [((NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1)-1:0] fail_hart_o,
    output logic [HALT_CODE_W-1:0]             fail_code_o,
    output logic [CNT_W-1:0]                   cycles_o,
    output logic [CNT_W-1:0]                   retired_o,
    output logic [NUM_HARTS-1:0]               halted_o
);

    localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int PW = $clog2(NUM_HARTS + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STALL_CYCLES - 1);

    state_e                 state_q;
    logic [RW-1:0]          rst_cnt_q;
    logic [CNT_W-1:0]       cycles_q;
    logic [CNT_W-1:0]       retired_q;
    logic [CNT_W-1:0]       stall_cnt_q;
    logic                   soc_rst_q;
    logic                   running_q;
    logic                   done_q;
    logic                   pass_q;
    logic                   timeout_q;
    logic                   stall_q;
    logic [HW-1:0]          fail_hart_q;
    logic [HALT_CODE_W-1:0] fail_code_q;

    logic [NUM_HARTS-1:0]   ret_w;
    logic [NUM_HARTS-1:0]   new_w;
    logic [NUM_HARTS-1:0]   halted_w;
    logic [HALT_CODE_W-1:0] code_w [NUM_HARTS];
    logic                   run_en;

    assign run_en = (state_q == RUN);

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
        svc_soc_run_monitor_hart u_hart (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .en_i        (run_en),
            .retire_i    (retire_i[g]),
            .halt_valid_i(halt_valid_i[g]),
            .halt_code_i (halt_code_i[g*HALT_CODE_W +: HALT_CODE_W]),
            .retire_o    (ret_w[g]),
            .new_halt_o  (new_w[g]),
            .halted_o    (halted_w[g]),
            .code_o      (code_w[g])
        );
    end

    logic [PW-1:0]          ret_cnt;
    logic                   fail_hit;
    logic [HW-1:0]          fail_idx;
    logic [HALT_CODE_W-1:0] fail_code;
    logic                   codes_zero;
    logic                   all_pass;
    logic [CNT_W:0]         retired_sum;
    logic [CNT_W-1:0]       cycles_d;
    logic [CNT_W-1:0]       retired_d;
    logic [CNT_W-1:0]       stall_cnt_d;
    cause_e                 cause;

    // Scan from the top index down so the lowest failing hart is the one left standing.
    always_comb begin
        ret_cnt    = '0;
        fail_hit   = 1'b0;
        fail_idx   = '0;
        fail_code  = '0;
        codes_zero = 1'b1;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            ret_cnt = ret_cnt + PW'(ret_w[i]);
            if ((halted_w[i] || new_w[i]) && (code_w[i] != '0)) begin
                codes_zero = 1'b0;
            end
            if (new_w[i] && (code_w[i] != '0)) begin
                fail_hit  = 1'b1;
                fail_idx  = HW'(i);
                fail_code = code_w[i];
            end
        end
        all_pass = (&(halted_w | new_w)) && codes_zero;

        cycles_d    = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
        retired_sum = {1'b0, retired_q} + (CNT_W + 1)'(ret_cnt);
        retired_d   = retired_sum[CNT_W] ? '1 : retired_sum[CNT_W-1:0];
        if (ret_cnt != '0) begin
            stall_cnt_d = '0;
        end else begin
            stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end

        cause = CAUSE_NONE;
        if (fail_hit) begin
            cause = CAUSE_FAIL;
        end else if (all_pass) begin
            cause = CAUSE_PASS;
        end else if ((WATCHDOG_CYCLES != 0) && (cycles_q == WD_LAST)) begin
            cause = CAUSE_TIMEOUT;
        end else if ((STALL_CYCLES != 0) && (ret_cnt == '0) && (stall_cnt_q == ST_LAST)) begin
            cause = CAUSE_STALL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RESET;
            rst_cnt_q   <= '0;
            cycles_q    <= '0;
            retired_q   <= '0;
            stall_cnt_q <= '0;
            soc_rst_q   <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stall_q     <= 1'b0;
            fail_hart_q <= '0;
            fail_code_q <= '0;
        end else begin
            case (state_q)
                RESET: begin
                    if (rst_cnt_q == RW'(RESET_CYCLES)) begin
                        state_q   <= RUN;
                        soc_rst_q <= 1'b0;
                        running_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cycles_q    <= cycles_d;
                    retired_q   <= retired_d;
                    stall_cnt_q <= stall_cnt_d;
                    if (cause != CAUSE_NONE) begin
                        state_q   <= END;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= (cause == CAUSE_PASS);
                        timeout_q <= (cause == CAUSE_TIMEOUT);
                        stall_q   <= (cause == CAUSE_STALL);
                        if (cause == CAUSE_FAIL) begin
                            fail_hart_q <= fail_idx;
                            fail_code_q <= fail_code;
                        end
                    end
                end
                END: begin
                    state_q <= END;
                end
                default: begin
                    state_q <= RESET;
                end
            endcase
        end
    end

    assign soc_rst_o   = soc_rst_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign stall_o     = stall_q;
    assign fail_hart_o = fail_hart_q;
    assign fail_code_o = fail_code_q;
    assign cycles_o    = cycles_q;
    assign retired_o   = retired_q;
    assign halted_o    = halted_w;

endmodule
